// File: rtl/apb_arb_pkg.sv
// apb_arbiter2 shared types: arbiter FSM states and the
// read data returned on a timed-out slave access.
package apb_arb_pkg;

    typedef enum logic [1:0] {
        IDLE,
        SETUP,
        ACCESS,
        RESP
    } arb_state_e;

    localparam logic [31:0] TIMEOUT_RDATA = 32'hDEADBEEF;

endpackage

// File: rtl/apb_arb_rr2.sv
// Two-way round-robin picker: a lone requester wins,
// a tie goes to the master that was not granted last.
module apb_arb_rr2 (
    input  logic [1:0] req,
    input  logic       last,
    output logic       gnt_idx,
    output logic       gnt_vld
);

    // Pick the winner from the request pair and last grant
    always_comb begin
        gnt_vld = |req;
        gnt_idx = 1'b0;
        case (req)
            2'b01:   gnt_idx = 1'b0;
            2'b10:   gnt_idx = 1'b1;
            2'b11:   gnt_idx = ~last;
            default: gnt_idx = 1'b0;
        endcase
    end

endmodule

// File: rtl/apb_arbiter2.sv
// Two-master APB3 arbiter: round-robin grant, re-timed slave transfer.
// Optional ACCESS timeout enabled by defining APB_ARB_TIMEOUT_EN.
module apb_arbiter2
    import apb_arb_pkg::*;
#(
    parameter int ADDR_W      = 32,
    parameter int DATA_W      = 32,
    parameter int TIMEOUT_CYC = 255
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              m0_psel,
    input  logic              m0_penable,
    input  logic              m0_pwrite,
    input  logic [ADDR_W-1:0] m0_paddr,
    input  logic [DATA_W-1:0] m0_pwdata,
    output logic [DATA_W-1:0] m0_prdata,
    output logic              m0_pready,
    output logic              m0_pslverr,
    input  logic              m1_psel,
    input  logic              m1_penable,
    input  logic              m1_pwrite,
    input  logic [ADDR_W-1:0] m1_paddr,
    input  logic [DATA_W-1:0] m1_pwdata,
    output logic [DATA_W-1:0] m1_prdata,
    output logic              m1_pready,
    output logic              m1_pslverr,
    output logic              s_psel,
    output logic              s_penable,
    output logic              s_pwrite,
    output logic [ADDR_W-1:0] s_paddr,
    output logic [DATA_W-1:0] s_pwdata,
    input  logic [DATA_W-1:0] s_prdata,
    input  logic              s_pready,
    input  logic              s_pslverr
);

    arb_state_e        state_q, state_d;
    logic              last_q, last_d;
    logic              gnt_q, gnt_d;
    logic              psel_q, psel_d;
    logic              penable_q, penable_d;
    logic              pwrite_q, pwrite_d;
    logic [ADDR_W-1:0] paddr_q, paddr_d;
    logic [DATA_W-1:0] pwdata_q, pwdata_d;
    logic [DATA_W-1:0] rdata_q, rdata_d;
    logic              err_q, err_d;
    logic              rsp_q, rsp_d;

    logic              rr_idx;
    logic              rr_vld;

    // Masters' penable is not needed: psel alone marks a request
    logic              penable_unused;
    assign penable_unused = m0_penable | m1_penable;

`ifdef APB_ARB_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TIMEOUT_CYC);
    logic [CNT_W-1:0] cnt_q, cnt_d;
`else
    logic [31:0] tmo_unused;
    assign tmo_unused = 32'(TIMEOUT_CYC);
`endif

    apb_arb_rr2 u_rr (
        .req     ({m1_psel, m0_psel}),
        .last    (last_q),
        .gnt_idx (rr_idx),
        .gnt_vld (rr_vld)
    );

    // Next-state, slave-side controls and response capture
    always_comb begin
        state_d   = state_q;
        last_d    = last_q;
        gnt_d     = gnt_q;
        psel_d    = 1'b0;
        penable_d = 1'b0;
        pwrite_d  = pwrite_q;
        paddr_d   = paddr_q;
        pwdata_d  = pwdata_q;
        rdata_d   = rdata_q;
        err_d     = err_q;
        rsp_d     = 1'b0;
`ifdef APB_ARB_TIMEOUT_EN
        cnt_d     = cnt_q;
`endif
        case (state_q)
            IDLE: begin
                if (rr_vld) begin
                    state_d  = SETUP;
                    gnt_d    = rr_idx;
                    last_d   = rr_idx;
                    psel_d   = 1'b1;
                    pwrite_d = rr_idx ? m1_pwrite : m0_pwrite;
                    paddr_d  = rr_idx ? m1_paddr  : m0_paddr;
                    pwdata_d = rr_idx ? m1_pwdata : m0_pwdata;
                end
            end
            SETUP: begin
                state_d   = ACCESS;
                psel_d    = 1'b1;
                penable_d = 1'b1;
`ifdef APB_ARB_TIMEOUT_EN
                cnt_d     = '0;
`endif
            end
            ACCESS: begin
                if (s_pready) begin
                    state_d = RESP;
                    rsp_d   = 1'b1;
                    err_d   = s_pslverr;
                    if (!pwrite_q) begin
                        rdata_d = s_prdata;
                    end
                end
`ifdef APB_ARB_TIMEOUT_EN
                else if (cnt_q == CNT_MAX) begin
                    state_d = RESP;
                    rsp_d   = 1'b1;
                    err_d   = 1'b1;
                    rdata_d = DATA_W'(TIMEOUT_RDATA);
                end
`endif
                else begin
                    psel_d    = 1'b1;
                    penable_d = 1'b1;
`ifdef APB_ARB_TIMEOUT_EN
                    cnt_d     = cnt_q + CNT_W'(1);
`endif
                end
            end
            RESP: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and output registers; reset abandons any transfer
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= IDLE;
            last_q    <= 1'b1;
            gnt_q     <= 1'b0;
            psel_q    <= 1'b0;
            penable_q <= 1'b0;
            pwrite_q  <= 1'b0;
            paddr_q   <= '0;
            pwdata_q  <= '0;
            rdata_q   <= '0;
            err_q     <= 1'b0;
            rsp_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            last_q    <= last_d;
            gnt_q     <= gnt_d;
            psel_q    <= psel_d;
            penable_q <= penable_d;
            pwrite_q  <= pwrite_d;
            paddr_q   <= paddr_d;
            pwdata_q  <= pwdata_d;
            rdata_q   <= rdata_d;
            err_q     <= err_d;
            rsp_q     <= rsp_d;
        end
    end

`ifdef APB_ARB_TIMEOUT_EN
    // ACCESS wait counter
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end
`endif

    assign s_psel     = psel_q;
    assign s_penable  = penable_q;
    assign s_pwrite   = pwrite_q;
    assign s_paddr    = paddr_q;
    assign s_pwdata   = pwdata_q;

    assign m0_prdata  = rdata_q;
    assign m1_prdata  = rdata_q;
    assign m0_pready  = rsp_q & ~gnt_q;
    assign m1_pready  = rsp_q &  gnt_q;
    assign m0_pslverr = rsp_q & ~gnt_q & err_q;
    assign m1_pslverr = rsp_q &  gnt_q & err_q;

endmodule

// File: doc/apb_arbiter2.md
# apb_arbiter2

Two-master APB3 arbiter that shares one APB3 slave bus between the UART command master and a second requester (on-chip debug/DMA sequencer). Each master issues normal APB3 transfers on its own port. The arbiter grants one master at a time with round-robin priority and re-times the granted transfer onto the slave side. It returns the slave's response to the granted master only; the other master is stalled with pready low.

## Interface
Parameters:
- ADDR_W, 32, address width for both masters and the slave
- DATA_W, 32, read/write data width
- TIMEOUT_CYC, 255, cycles in ACCESS before forced termination (only with the timeout feature)

Ports:
- clk  input  1  APB clock; all logic on rising edge
- reset_n  input  1  asynchronous, active-low reset
- m0_psel, m1_psel  input  1  master request (APB3 setup/access select)
- m0_penable, m1_penable  input  1  master access phase
- m0_pwrite, m1_pwrite  input  1  1 = write
- m0_paddr, m1_paddr  input  ADDR_W  master address
- m0_pwdata, m1_pwdata  input  DATA_W  master write data
- m0_prdata, m1_prdata  output  DATA_W  read data, valid with pready
- m0_pready, m1_pready  output  1  one-cycle completion pulse to that master
- m0_pslverr, m1_pslverr  output  1  error, valid with pready
- s_psel, s_penable, s_pwrite  output  1  slave-side APB3 controls
- s_paddr  output  ADDR_W  registered address
- s_pwdata  output  DATA_W  registered write data
- s_prdata  input  DATA_W  slave read data
- s_pready, s_pslverr  input  1  slave completion / error

## Operation
- FSM: IDLE → SETUP → ACCESS → RESP → IDLE. One transfer is in flight at a time.
- IDLE: a master requests when mX_psel=1. If exactly one requests, grant it. If both request, grant the master not granted last. `last` resets to 1, so m0 wins the first tie.
- On the grant cycle, latch paddr/pwrite/pwdata of the granted master into s_* registers. Store the grant index and update `last`.
- SETUP: s_psel=1, s_penable=0, for one cycle.
- ACCESS: s_psel=1, s_penable=1. Stay until s_pready=1. On that cycle, capture s_prdata (reads only; writes leave the register unchanged) and s_pslverr.
- RESP: s_psel=s_penable=0. The granted master's mX_pready=1 for exactly this cycle, with mX_prdata and mX_pslverr driven from the capture registers.
- Non-granted master: pready=0, pslverr=0, prdata = capture register. Its request persists and is served on the next IDLE.
- Masters must hold psel and the other inputs stable until their pready. The arbiter never samples them after the grant.
- A master dropping psel after grant does not cancel the transfer. The slave transfer completes and the RESP pulse is still issued.

## Timing
- Reset (asynchronous, any state): state=IDLE, last=1. All s_* outputs are 0, all mX_pready/mX_pslverr are 0, and the capture registers are 0. An in-flight transfer is abandoned.
- With the request sampled in IDLE at cycle T: s_psel rises at T+1 and s_penable at T+2.
- If s_pready=1 at T+2, mX_pready pulses at T+3. Minimum master-visible latency is 3 cycles. Each slave wait state adds 1.
- IDLE is entered at RESP+1, where a pending request is sampled. Back-to-back transfers therefore occupy 4 cycles each. Under continuous contention, m0 and m1 alternate.
- s_paddr, s_pwrite and s_pwdata hold their values through IDLE until the next grant.

## Configuration
- APB_ARB_TIMEOUT_EN defined:
  - Include a counter of width $clog2(TIMEOUT_CYC+1), cleared on entry to ACCESS and incremented each ACCESS cycle without s_pready.
  - When the count reaches TIMEOUT_CYC with s_pready still 0, go to RESP with pslverr=1 and prdata=DATA_W'hDEADBEEF (truncated or zero-extended to DATA_W).
  - s_pready arriving on the terminal cycle wins: normal completion.
- Not defined: no counter. ACCESS waits indefinitely; pslverr reflects s_pslverr only.

## Structure
- Package apb_arb_pkg holds the state enum (IDLE, SETUP, ACCESS, RESP) and the timeout read-data constant.
- Sub-module apb_arb_rr2 is the 2-way round-robin picker: inputs req[1:0] and last, outputs gnt_idx and gnt_vld. It is combinational and instantiated once.

## Test plan
- Single read: only m0 requests addr 0x10, s_prdata=0x12345678, s_pready=1 on first ACCESS → s_psel at T+1, s_penable at T+2, m0_pready and m0_prdata=0x12345678 at T+3; m1_pready stays 0.
- Simultaneous requests after reset: m0 write 0x20/0xA5, m1 read 0x30 → m0 served first, m1's s_psel at m0-RESP+2; three further tied rounds alternate m1, m0, m1.
- Wait states: slave holds s_pready=0 for 5 ACCESS cycles → s_penable held for 6 cycles, master pready at T+8, address and data stable throughout.
- Slave error: s_pslverr=1 with s_pready → granted master sees pslverr=1 with pready; the other master sees none.
- Reset mid-ACCESS: reset_n low during a stalled transfer → all outputs 0 immediately; after release, m0 wins the next tie.
- APB_ARB_TIMEOUT_EN with TIMEOUT_CYC=4, slave never ready → pready at T+7 with pslverr=1 and prdata=0xDEADBEEF; FSM returns to IDLE.
